apb_reg_slave: RTL and testbench
================================

// Module: apb_reg_slave
// PURPOSE
//  APB3 completer on one psel line of the AXI-to-APB bridge (psel_o[0] or [1]), bridge paddr/pwrite/pwdata/penable in.
//  Provides NUM_REGS word-wide read/write scratch registers with programmable wait states and PSLVERR on bad accesses.
//  Used as the reference peripheral for bridge bring-up and as a template for real peripherals.
// PARAMETERS
//  ADDR_WIDTH   32  APB address width; only paddr_i[15:0] decoded (upper bits are the bridge's slave select)
//  DATA_WIDTH   32  APB data width; registers are DATA_WIDTH wide
//  NUM_REGS     16  scratch registers at offsets 0x0..(NUM_REGS-1)*4; 1..256
//  WAIT_CYCLES  2   ACCESS-phase wait states before pready_o; 0..15 (0 = zero-wait)
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  rst_n      in   1           asynchronous active-low reset
//  psel_i     in   1           APB select for this completer
//  penable_i  in   1           APB enable (ACCESS phase)
//  pwrite_i   in   1           1 = write, 0 = read
//  paddr_i    in   ADDR_WIDTH  byte address
//  pwdata_i   in   DATA_WIDTH  write data
//  prdata_o   out  DATA_WIDTH  read data, valid only while pready_o=1 on a read
//  pready_o   out  1           transfer complete
//  pslverr_o  out  1           error, valid only while pready_o=1
// BEHAVIOUR
//  - Reset: all outputs 0, all registers 0, FSM in S_IDLE, wait counter 0.
//  - Offset off=paddr_i[15:0]; legal iff off[1:0]==0 and off[15:2]<NUM_REGS (plus counter slot, see CONFIGURATION).
//  - FSM S_IDLE / S_ACCESS:
//    - S_IDLE: psel_i & ~penable_i (SETUP) -> S_ACCESS, wcnt<=WAIT_CYCLES.
//      psel_i & penable_i with no prior SETUP is ignored (no pready_o, no write).
//    - S_ACCESS:
//      - ~psel_i -> S_IDLE, abort, no register update.
//      - psel_i & penable_i & wcnt!=0 -> wcnt<=wcnt-1.
//      - psel_i & penable_i & wcnt==0 -> completion cycle -> S_IDLE.
//  - pready_o = (state==S_ACCESS) & psel_i & penable_i & (wcnt==0); combinational from registered state, high for exactly 1 cycle per transfer.
//    Transfer occupies 2+WAIT_CYCLES cycles: SETUP, WAIT_CYCLES waits, completion.
//  - Address, pwrite_i and pwdata_i are sampled at the completion edge; the upstream holds them stable through ACCESS.
//  - Write: on completion edge, legal offset -> reg[off>>2]<=pwdata_i; illegal -> no update, pslverr_o=1.
//  - Read: on completion cycle, prdata_o=reg[off>>2] (legal) else 0 with pslverr_o=1. prdata_o=0 whenever pready_o=0.
//  - Back-to-back: a SETUP in the cycle right after completion is accepted (FSM already S_IDLE); no idle cycle required.
//    The bridge keeps psel high across bursts; only psel&~penable starts a transfer.
//  - Read-after-write to the same register in consecutive transfers returns the new value.
//  - wcnt is 4 bits; WAIT_CYCLES>15 is a parameter error (elaboration $error).
//  - Reset mid-transfer: immediate return to reset state; a write in flight is not committed.
// CONFIGURATION
//  APB_REG_XFER_CNT_EN defined:
//    - Extra read-only register at offset NUM_REGS*4: 32-bit count of completed transfers (reads+writes, incl. errored), wraps 0xFFFF_FFFF->0.
//    - Increments on each completion edge. A read of it returns the pre-increment value.
//    - A write to it is an error (pslverr_o=1) and still counts.
//  APB_REG_XFER_CNT_EN undefined: counter logic absent; offset NUM_REGS*4 is unmapped -> pslverr_o=1.
// TESTING (WAIT_CYCLES=2, NUM_REGS=16 unless noted)
//  1. Write 0xDEADBEEF @0x08, then read @0x08 -> pready_o on 4th cycle of each transfer, prdata_o=0xDEADBEEF, pslverr_o=0.
//  2. Read @0x02 and write @0x40 -> pslverr_o=1 with pready_o, prdata_o=0, no register changed (read back all 16 = 0).
//  3. WAIT_CYCLES=0 build: write 0x1234 @0x3C back-to-back with read @0x3C -> pready_o in each ENABLE cycle, read returns 0x1234.
//  4. Drop psel_i mid-ACCESS of write 0xA5A5A5A5 @0x04 -> no pready_o, reg[1] stays 0; the next transfer completes normally.
//  5. Assert rst_n=0 during wait of write @0x10 -> outputs 0 immediately, reg[4]=0 after reset; penable without SETUP ignored.
//  6. APB_REG_XFER_CNT_EN: 5 transfers then read @0x40 -> 5; write @0x40 -> pslverr_o=1, next read -> 7.

Source files
------------

// File: rtl/apb_reg_slave.sv
// APB3 completer exposing NUM_REGS scratch registers with programmable wait states and PSLVERR.
// Optional build macro APB_REG_XFER_CNT_EN adds a read-only completed-transfer counter at offset NUM_REGS*4.
module apb_reg_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o
);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("apb_reg_slave: WAIT_CYCLES must be 0..15");
        end
        if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_regs
            $error("apb_reg_slave: NUM_REGS must be 1..256");
        end
    endgenerate

    localparam int             IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0]     WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [13:0]    NREG_W    = 14'(NUM_REGS);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      wcnt, wcnt_nxt;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_data;
    logic [15:0]     off;
    logic [13:0]     word_idx;
    logic [IDX_W-1:0] reg_idx;
    logic            aligned;
    logic            reg_hit;
    logic            bad_access;
    logic            unused_addr;

    assign off         = paddr_i[15:0];
    assign word_idx    = off[15:2];
    assign reg_idx     = word_idx[IDX_W-1:0];
    assign aligned     = (off[1:0] == 2'b00);
    assign reg_hit     = aligned && (word_idx < NREG_W);
    // Upper address bits belong to the bridge's slave select and are not decoded here.
    assign unused_addr = ^paddr_i[ADDR_WIDTH-1:16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            S_IDLE: begin
                if (psel_i && !penable_i) begin
                    state_nxt = S_ACCESS;
                    wcnt_nxt  = WAIT_INIT;
                end
            end
            S_ACCESS: begin
                if (!psel_i) begin
                    state_nxt = S_IDLE;
                end else if (penable_i) begin
                    if (wcnt != 4'd0) begin
                        wcnt_nxt = wcnt - 4'd1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign pready_o = (state == S_ACCESS) && psel_i && penable_i && (wcnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (pready_o && pwrite_i && reg_hit) begin
            regs[reg_idx] <= pwdata_i;
        end
    end

`ifdef APB_REG_XFER_CNT_EN
    logic [31:0] xfer_cnt;
    logic        cnt_hit;

    assign cnt_hit = aligned && (word_idx == NREG_W);

    // Counts every completion, including errored ones; reads see the pre-increment value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= 32'd0;
        end else if (pready_o) begin
            xfer_cnt <= xfer_cnt + 32'd1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (reg_hit) begin
            rd_data = regs[reg_idx];
        end else if (cnt_hit) begin
            rd_data = DATA_WIDTH'(xfer_cnt);
        end
    end

    assign bad_access = !(reg_hit || (cnt_hit && !pwrite_i));
`else
    always_comb begin
        rd_data = '0;
        if (reg_hit) begin
            rd_data = regs[reg_idx];
        end
    end

    assign bad_access = !reg_hit;
`endif

    assign prdata_o  = (pready_o && !pwrite_i) ? rd_data : '0;
    assign pslverr_o = pready_o && bad_access;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: a WAIT_CYCLES=2 instance plus a zero-wait instance on the same bus.
module tb_apb_reg_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    apb_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0)
    );

    apb_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(0)) dut_zw (
        .clk(clk), .rst_n(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata1), .pready_o(pready1), .pslverr_o(pslverr1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One APB transfer; leaves the bus untouched after completion so the next call is back-to-back.
    task automatic xfer(input bit use_zw, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int cyc);
        bit   done;
        logic rdy;
        done  = 1'b0;
        rdata = '0;
        err   = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 2;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            rdy = use_zw ? pready1 : pready0;
            if (rdy) begin
                rdata = use_zw ? prdata1 : prdata0;
                err   = use_zw ? pslverr1 : pslverr0;
                done  = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("xfer_completed", {31'd0, done}, 32'd1);
    endtask

    task automatic do_wr(input string tag, input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        int          cyc;
        xfer(1'b0, 1'b1, addr, data, rd, err, cyc);
        chk({tag, "_cycles"}, 32'(cyc), 32'd4);
        chk({tag, "_pslverr"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, "_prdata"}, rd, 32'd0);
    endtask

    task automatic do_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        int          cyc;
        xfer(1'b0, 1'b0, addr, 32'd0, rd, err, cyc);
        chk({tag, "_cycles"}, 32'(cyc), 32'd4);
        chk({tag, "_pslverr"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, "_prdata"}, rd, exp_data);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("idle_pready", {31'd0, pready0}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          cyc;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pready", {31'd0, pready0}, 32'd0);
        chk("reset_pslverr", {31'd0, pslverr0}, 32'd0);
        chk("reset_prdata", prdata0, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Bad accesses raise PSLVERR and change nothing
        do_rd("t2_rd_unaligned", 32'h0000_0002, 32'd0, 1'b1);
        do_wr("t2_wr_oob", 32'h0000_0040, 32'hFFFF_FFFF, 1'b1);
        do_wr("t2_wr_unaligned", 32'h0000_000A, 32'h0000_0001, 1'b1);
`ifndef APB_REG_XFER_CNT_EN
        do_rd("t2_rd_cnt_unmapped", 32'h0000_0040, 32'd0, 1'b1);
`endif
        for (int i = 0; i < 16; i++) begin
            do_rd($sformatf("t2_clean_r%0d", i), 32'(i * 4), 32'd0, 1'b0);
        end
        go_idle();

        // Write then back-to-back read
        do_wr("t1_wr", 32'h0000_0008, 32'hDEAD_BEEF, 1'b0);
        do_rd("t1_rd", 32'h0000_0008, 32'hDEAD_BEEF, 1'b0);
        go_idle();

        // Distinct pattern in every register, then read back
        for (int i = 0; i < 16; i++) begin
            do_wr($sformatf("pat_wr%0d", i), 32'(i * 4), 32'h0F1E_2D3C ^ (32'(i) * 32'h0101_0101), 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            do_rd($sformatf("pat_rd%0d", i), 32'(i * 4), 32'h0F1E_2D3C ^ (32'(i) * 32'h0101_0101), 1'b0);
        end
        do_wr("alias_wr", 32'h1000_000C, 32'hCAFE_F00D, 1'b0);
        do_rd("alias_rd", 32'h0000_000C, 32'hCAFE_F00D, 1'b0);
        go_idle();

        // Abort by dropping psel mid-ACCESS
        do_reset();
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0004; pwdata = 32'hA5A5_A5A5;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        chk("t4_wait_pready", {31'd0, pready0}, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("t4_abort_pready", {31'd0, pready0}, 32'd0);
        do_rd("t4_rd_after_abort", 32'h0000_0004, 32'd0, 1'b0);
        go_idle();

        // Reset during a write; reset clears registers; ENABLE without SETUP ignored
        do_wr("t5_pre_wr", 32'h0000_0010, 32'h0000_0055, 1'b0);
        do_rd("t5_pre_rd", 32'h0000_0010, 32'h0000_0055, 1'b0);
        go_idle();
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0010; pwdata = 32'h0000_0099;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_pre_rst_pready", {31'd0, pready0}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_pready", {31'd0, pready0}, 32'd0);
        chk("t5_rst_pslverr", {31'd0, pslverr0}, 32'd0);
        chk("t5_rst_prdata", prdata0, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
        do_rd("t5_rd_after_rst", 32'h0000_0010, 32'd0, 1'b0);
        go_idle();
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0000_0010; pwdata = 32'h0000_0077;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5_nosetup_pready%0d", i), {31'd0, pready0}, 32'd0);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        do_rd("t5_rd_nosetup", 32'h0000_0010, 32'd0, 1'b0);
        go_idle();

`ifdef APB_REG_XFER_CNT_EN
        // Completed-transfer counter
        do_reset();
        do_wr("t6_x1", 32'h0000_0000, 32'h0000_0001, 1'b0);
        do_wr("t6_x2", 32'h0000_0004, 32'h0000_0002, 1'b0);
        do_wr("t6_x3", 32'h0000_0008, 32'h0000_0003, 1'b0);
        do_rd("t6_x4", 32'h0000_0000, 32'h0000_0001, 1'b0);
        do_rd("t6_x5", 32'h0000_0004, 32'h0000_0002, 1'b0);
        do_rd("t6_cnt5", 32'h0000_0040, 32'd5, 1'b0);
        do_wr("t6_cnt_wr", 32'h0000_0040, 32'h0000_1234, 1'b1);
        do_rd("t6_cnt7", 32'h0000_0040, 32'd7, 1'b0);
        go_idle();
`endif

        // Zero-wait instance, back-to-back write and read
        do_reset();
        xfer(1'b1, 1'b1, 32'h0000_003C, 32'h0000_1234, rd, err, cyc);
        chk("t3_wr_cycles", 32'(cyc), 32'd2);
        chk("t3_wr_pslverr", {31'd0, err}, 32'd0);
        xfer(1'b1, 1'b0, 32'h0000_003C, 32'd0, rd, err, cyc);
        chk("t3_rd_cycles", 32'(cyc), 32'd2);
        chk("t3_rd_pslverr", {31'd0, err}, 32'd0);
        chk("t3_rd_prdata", rd, 32'h0000_1234);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
